// File: rtl/vga_fb_pkg.sv
// Shared types for the framebuffer arbiter: default bus widths and the arbiter state encoding.
// No logic, no latency, no flow control.
package vga_fb_pkg;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } arb_state_t;
endpackage

// File: rtl/fb_rd_return_pipe.sv
// Read-return path: 2-stage valid shift tracking mem_re, plus the disp_rdata capture register.
// Latency 2 cycles from mem_re to rvalid; no backpressure, the display always accepts.
module fb_rd_return_pipe #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_issue_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o
);
    logic [1:0]        vld_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 2'b00;
            rdata_q <= '0;
        end else begin
            vld_q <= {vld_q[0], rd_issue_i};
            // RAM data is on mem_rdata only in the cycle after mem_re.
            if (vld_q[0]) begin
                rdata_q <= mem_rdata_i;
            end
        end
    end

    assign rvalid_o = vld_q[1];
    assign rdata_o  = rdata_q;
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads win in active video, writes win in blanking, starvation forces a write slot.
// Grants are combinational; read data 3 cycles after grant. Optional FB_ARB_STATS_EN adds the wr_stall_cnt port.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              blank_n,
    input  logic              frame_start,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]       wr_stall_cnt
`endif
);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        starve_q, starve_d;
    logic              run_q;
    logic              wr_win;

    always_comb begin
        // run_q keeps both grants low during reset and the first cycle after release.
        wr_win   = run_q && wr_req && (!blank_n || !disp_req || (starve_q == STARVE_LIM));
        wr_gnt   = wr_win;
        disp_gnt = run_q && disp_req && !wr_win;

        if (!wr_req || wr_win) begin
            starve_d = 8'd0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 8'd1;
        end else begin
            starve_d = starve_q;
        end

        state_d = S_IDLE;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (wr_win) begin
            state_d = S_WR;
            addr_d  = wr_addr;
            wdata_d = wr_data;
        end else if (disp_gnt) begin
            state_d = S_RD;
            addr_d  = disp_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            starve_q <= 8'd0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
            run_q    <= 1'b1;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = (state_q == S_WR);
    assign mem_re    = (state_q == S_RD);

    fb_rd_return_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk         (clk),
        .rst_n       (reset),
        .rd_issue_i  (mem_re),
        .mem_rdata_i (mem_rdata),
        .rvalid_o    (disp_rvalid),
        .rdata_o     (disp_rdata)
    );

`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= 16'd0;
        end else if (frame_start) begin
            stall_q <= 16'd0;
        end else if (wr_req && !wr_win && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign wr_stall_cnt = stall_q;
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter: a grant/memory model checked every cycle plus directed literal scenarios.
module tb_vga_fb_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int SM = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          blank_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          disp_gnt, disp_rvalid, wr_gnt, mem_we, mem_re;
    logic [DW-1:0] disp_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
`ifdef FB_ARB_STATS_EN
    logic [15:0]   wr_stall_cnt;
`endif

    always #20 clk = ~clk;

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk         (clk),
        .reset       (reset),
        .blank_n     (blank_n),
        .frame_start (frame_start),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_gnt      (wr_gnt),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata)
`ifdef FB_ARB_STATS_EN
        ,
        .wr_stall_cnt(wr_stall_cnt)
`endif
    );

    // Synchronous single-port RAM, read-before-write.
    logic [DW-1:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state
    logic [DW-1:0] shadow [0:65535];
    int            starve_m = 0;
    int            stall_m = 0;
    bit            run_m = 0;
    bit            pe_re = 0, pe_we = 0;
    logic [AW-1:0] pe_addr = '0;
    logic [DW-1:0] pe_wdata = '0;
    int            due_q[$];
    logic [DW-1:0] dat_q[$];
    bit            last_dg = 0, last_wg = 0;

    always @(negedge clk) begin
        bit eg_d, eg_w, rv;
        cyc++;
        if (!reset) begin
            chk("m_rst_dgnt", disp_gnt, 0);
            chk("m_rst_wgnt", wr_gnt, 0);
            chk("m_rst_re", mem_re, 0);
            chk("m_rst_we", mem_we, 0);
            chk("m_rst_addr", mem_addr, 0);
            chk("m_rst_wdata", mem_wdata, 0);
            chk("m_rst_rvalid", disp_rvalid, 0);
            chk("m_rst_rdata", disp_rdata, 0);
`ifdef FB_ARB_STATS_EN
            chk("m_rst_stall", wr_stall_cnt, 0);
`endif
            starve_m = 0; stall_m = 0; run_m = 0;
            pe_re = 0; pe_we = 0;
            due_q.delete(); dat_q.delete();
        end else begin
            eg_w = run_m && wr_req && (!blank_n || !disp_req || starve_m == SM);
            eg_d = run_m && disp_req && !eg_w;
            chk("m_disp_gnt", disp_gnt, eg_d);
            chk("m_wr_gnt", wr_gnt, eg_w);
            chk("m_mem_re", mem_re, pe_re);
            chk("m_mem_we", mem_we, pe_we);
            if (pe_re || pe_we) chk("m_mem_addr", mem_addr, pe_addr);
            if (pe_we) chk("m_mem_wdata", mem_wdata, pe_wdata);
            rv = (due_q.size() > 0) && (due_q[0] == cyc);
            chk("m_rvalid", disp_rvalid, rv);
            if (rv) begin
                chk("m_rdata", disp_rdata, dat_q[0]);
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end
`ifdef FB_ARB_STATS_EN
            chk("m_stall", wr_stall_cnt, stall_m);
`endif
            pe_re = eg_d;
            pe_we = eg_w;
            pe_addr = eg_w ? wr_addr : disp_addr;
            pe_wdata = wr_data;
            if (eg_d) begin
                due_q.push_back(cyc + 3);
                dat_q.push_back(shadow[disp_addr]);
            end
            if (eg_w) shadow[wr_addr] = wr_data;
            if (!wr_req || eg_w) starve_m = 0;
            else if (starve_m < SM) starve_m++;
            if (frame_start) stall_m = 0;
            else if (wr_req && !eg_w && stall_m < 65535) stall_m++;
            run_m = 1;
        end
        last_dg = disp_gnt;
        last_wg = wr_gnt;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Keep both requests asserted, presenting a fresh transaction after each grant.
    task automatic hold_step();
        step();
        if (last_dg) disp_addr = 16'($urandom_range(0, 31));
        if (last_wg) begin
            wr_addr = 16'($urandom_range(0, 31));
            wr_data = 8'($urandom);
        end
    endtask

    task automatic rand_step(input int p_blank);
        step();
        if (!disp_req || last_dg) begin
            disp_req  = ($urandom_range(0, 3) != 0);
            disp_addr = 16'($urandom_range(0, 31));
        end
        if (!wr_req || last_wg) begin
            wr_req  = ($urandom_range(0, 2) != 0);
            wr_addr = 16'($urandom_range(0, 31));
            wr_data = 8'($urandom);
        end
        if ($urandom_range(0, 99) < p_blank) blank_n = ~blank_n;
        frame_start = ($urandom_range(0, 49) == 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]    = 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end
        ram[16'h0042]    = 8'hA5;
        shadow[16'h0042] = 8'hA5;

        // Reset held with a pending display request
        #5 reset = 1'b0;
        disp_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_disp_gnt", disp_gnt, 0);
            chk("rst_mem_re", mem_re, 0);
        end
        step(); reset = 1'b1;
        @(negedge clk); chk("rel_no_gnt", disp_gnt, 0);
        @(negedge clk); chk("rel_first_gnt", disp_gnt, 1);

        // Starvation: 15 reads then one forced write, repeating
        step(); blank_n = 1'b1; wr_req = 1'b0; disp_req = 1'b1;
        step(); wr_req = 1'b1; wr_addr = 16'd3; wr_data = 8'h11;
        for (int i = 0; i < 48; i++) begin
            if (i > 0) hold_step();
            @(negedge clk);
            chk("starve_pat", {disp_gnt, wr_gnt}, (i % 16 == 15) ? 32'd1 : 32'd2);
        end

        // Blanking: writer wins every cycle
        hold_step(); blank_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) hold_step();
            @(negedge clk);
            chk("blank_wr_gnt", wr_gnt, 1);
            chk("blank_no_disp", disp_gnt, 0);
        end
        hold_step(); wr_req = 1'b0;
        @(negedge clk); chk("blank_disp_after", disp_gnt, 1);

        // Single read of 0x0042
        step(); disp_req = 1'b0; blank_n = 1'b1;
        step(); disp_req = 1'b1; disp_addr = 16'h0042;
        @(negedge clk); chk("rd42_gnt", disp_gnt, 1);
        step(); disp_req = 1'b0;
        @(negedge clk);
        chk("rd42_mem_re", mem_re, 1);
        chk("rd42_mem_addr", mem_addr, 32'h42);
        @(negedge clk); chk("rd42_no_rvalid_yet", disp_rvalid, 0);
        @(negedge clk);
        chk("rd42_rvalid", disp_rvalid, 1);
        chk("rd42_rdata", disp_rdata, 32'hA5);
        @(negedge clk); chk("rd42_pulse_end", disp_rvalid, 0);

        // Reset one cycle after a read grant drops the read
        step(); disp_req = 1'b1; disp_addr = 16'd5;
        @(negedge clk); chk("rstmid_gnt", disp_gnt, 1);
        step(); disp_req = 1'b0; reset = 1'b0;
        repeat (4) begin
            @(negedge clk); chk("rstmid_no_rvalid", disp_rvalid, 0);
        end
        step(); reset = 1'b1;

`ifdef FB_ARB_STATS_EN
        step(); frame_start = 1'b1; wr_req = 1'b0; disp_req = 1'b0; blank_n = 1'b1;
        step(); frame_start = 1'b0; wr_req = 1'b1; disp_req = 1'b1;
        repeat (20) hold_step();
        step(); wr_req = 1'b0; disp_req = 1'b0;
        @(negedge clk); chk("stall_20", wr_stall_cnt, 20);
        step(); frame_start = 1'b1;
        step(); frame_start = 1'b0;
        @(negedge clk); chk("stall_clear", wr_stall_cnt, 0);
`endif

        // Randomized traffic with blanking toggles
        repeat (3000) rand_step(5);
        step(); disp_req = 1'b0; wr_req = 1'b0; frame_start = 1'b0;
        repeat (5) @(negedge clk);
        chk("drain_pending_reads", due_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
